// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline-control outputs of hazard_ctrl_unit
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      id_instr;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             branch_taken_ex;
    logic             dmem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_hold;
    logic             stall_active;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_instr, ex_mem_read, ex_rd, branch_taken_ex, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_active, stall_count
    );

    modport slave (
        input  id_instr, ex_mem_read, ex_rd, branch_taken_ex, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, stall_active, stall_count
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: multi-cycle load-use stall, branch flush and dmem-wait freeze control
module hazard_ctrl_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz_if
);
    typedef enum logic [1:0] {IDLE, LOAD_STALL, FLUSH, MEM_WAIT} state_e;

    localparam logic [2:0] LS_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d, saved_q, saved_d, cur;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [6:0]       opc;
    logic [4:0]       rs1, rs2;
    logic             use1, use2, load_use;
    logic             pc_we, ifid_we, flush, bubble, hold, bump;
    logic             unused_bits;

    assign opc         = hz_if.id_instr[6:0];
    assign rs1         = hz_if.id_instr[19:15];
    assign rs2         = hz_if.id_instr[24:20];
    assign unused_bits = ^{hz_if.id_instr[31:25], hz_if.id_instr[14:7]};
    assign use2        = opc inside {7'b0110011, 7'b0100011, 7'b1100011};
    assign use1        = use2 || (opc inside {7'b0010011, 7'b0000011, 7'b1100111});
    assign load_use    = hz_if.ex_mem_read && (hz_if.ex_rd != 5'd0) &&
                         ((use1 && rs1 == hz_if.ex_rd) || (use2 && rs2 == hz_if.ex_rd));

    // MEM_WAIT is transparent: once the memory is ready we act as the saved state this cycle
    assign cur = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d = cur;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        hold    = 1'b0;
        bump    = 1'b0;
        if (hz_if.dmem_busy) begin
            state_d = MEM_WAIT;
            saved_d = cur;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            hold    = 1'b1;
        end else if (hz_if.branch_taken_ex) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            cnt_d   = FL_INIT;
        end else if (cur == FLUSH) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = (cnt_q == 3'd1) ? IDLE : FLUSH;
            cnt_d   = cnt_q - 3'd1;
        end else if (cur == LOAD_STALL) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
            bump    = 1'b1;
            state_d = (cnt_q == 3'd1) ? IDLE : LOAD_STALL;
            cnt_d   = cnt_q - 3'd1;
        end else if (load_use) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
            bump    = 1'b1;
            state_d = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : IDLE;
            cnt_d   = LS_INIT;
        end
        count_d = (bump && count_q != '1) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            saved_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign hz_if.pc_write     = rst | pc_we;
    assign hz_if.if_id_write  = rst | ifid_we;
    assign hz_if.if_id_flush  = !rst & flush;
    assign hz_if.id_ex_bubble = !rst & bubble;
    assign hz_if.pipe_hold    = !rst & hold;
    assign hz_if.stall_active = !rst & ((state_q != IDLE) | flush | bubble | hold | !pc_we);
    assign hz_if.stall_count  = count_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: vector table, directed multi-cycle sequences and random run vs a count-based model
module tb_hazard_ctrl_unit;
    localparam logic [31:0] ADD  = 32'h00728333;
    localparam logic [31:0] ADDI = 32'h00100413;
    localparam logic [31:0] LUI  = 32'h000282B7;
    localparam logic [31:0] SW   = 32'h0092A023;
    localparam logic [31:0] JALR = 32'h000280E7;
    localparam logic [31:0] BEQ  = 32'h00600063;
    localparam logic [31:0] ADD0 = 32'h00000333;

    localparam logic [5:0] NORM = 6'b110000;
    localparam logic [5:0] BUBL = 6'b000101;
    localparam logic [5:0] FLSH = 6'b111101;
    localparam logic [5:0] HOLD = 6'b000011;

    logic        clk = 1'b0;
    logic        rst, busy, br, mr;
    logic [4:0]  rd;
    logic [31:0] instr;
    logic [5:0]  oa, ob;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) ia ();
    hazard_ctrl_if #(.CNT_W(4))  ib ();

    assign ia.id_instr = instr;  assign ib.id_instr = instr;
    assign ia.ex_mem_read = mr;  assign ib.ex_mem_read = mr;
    assign ia.ex_rd = rd;        assign ib.ex_rd = rd;
    assign ia.branch_taken_ex = br; assign ib.branch_taken_ex = br;
    assign ia.dmem_busy = busy;  assign ib.dmem_busy = busy;
    assign oa = {ia.pc_write, ia.if_id_write, ia.if_id_flush, ia.id_ex_bubble, ia.pipe_hold, ia.stall_active};
    assign ob = {ib.pc_write, ib.if_id_write, ib.if_id_flush, ib.id_ex_bubble, ib.pipe_hold, ib.stall_active};

    hazard_ctrl_unit #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .hz_if(ia));
    hazard_ctrl_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hz_if(ib));

    // model: remaining bubble / flush cycles as plain counts, plus "was frozen last cycle"
    typedef struct {
        int load_left;
        int flush_left;
        int cnt;
        bit in_wait;
    } mstate_t;
    mstate_t ma, mb;

    typedef struct {
        logic        busy, br, mr;
        logic [4:0]  rd;
        logic [31:0] ins;
        logic [5:0]  exp;
        int          cnt;
    } vec_t;
    vec_t tbl[17];

    function automatic bit load_use_ref(logic [31:0] i, logic m, logic [4:0] d);
        logic [6:0] op = i[6:0];
        bit two = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        bit one = two || op == 7'h13 || op == 7'h03 || op == 7'h67;
        return m && d != 5'd0 && ((one && i[19:15] == d) || (two && i[24:20] == d));
    endfunction

    task automatic model_step(inout mstate_t s, input int ls, input int fc, input int w, output logic [5:0] o);
        bit pending = s.in_wait || s.load_left > 0 || s.flush_left > 0;
        bit lu = load_use_ref(instr, mr, rd);
        o = NORM;
        if (rst) begin
            s = '{0, 0, 0, 0};
            return;
        end
        if (busy) begin
            o = HOLD;
            s.in_wait = 1;
        end else begin
            s.in_wait = 0;
            if (br) begin
                o = FLSH;
                s.load_left = 0;
                s.flush_left = fc - 1;
            end else if (s.flush_left > 0) begin
                o = FLSH;
                s.flush_left--;
            end else if (s.load_left > 0 || lu) begin
                o = BUBL;
                s.cnt = (s.cnt < (1 << w) - 1) ? s.cnt + 1 : s.cnt;
                s.load_left = (s.load_left > 0) ? s.load_left - 1 : ls - 1;
            end
        end
        if (pending) o[0] = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic t, input logic m,
                        input logic [4:0] d, input logic [31:0] ins);
        logic [5:0] ea, eb;
        int ca, cb;
        rst = r; busy = b; br = t; mr = m; rd = d; instr = ins;
        #3;
        ca = ma.cnt;
        cb = mb.cnt;
        model_step(ma, 1, 1, 16, ea);
        model_step(mb, 3, 2, 4, eb);
        check("model_a_out", 32'(oa), 32'(ea));
        check("model_a_cnt", 32'(ia.stall_count), ca);
        check("model_b_out", 32'(ob), 32'(eb));
        check("model_b_cnt", 32'(ib.stall_count), cb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; busy = 0; br = 0; mr = 0; rd = 0; instr = ADD;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
    endtask

    initial begin
        logic [31:0] pool[7];
        pool = '{ADD, ADDI, LUI, SW, JALR, BEQ, ADD0};

        tbl[0]  = '{0, 0, 0, 5'd0, ADD,  NORM, 0};
        tbl[1]  = '{0, 0, 1, 5'd5, ADD,  BUBL, 0};
        tbl[2]  = '{0, 0, 0, 5'd0, ADD,  NORM, 1};
        tbl[3]  = '{0, 0, 1, 5'd0, ADDI, NORM, 1};
        tbl[4]  = '{0, 0, 1, 5'd5, LUI,  NORM, 1};
        tbl[5]  = '{0, 0, 1, 5'd5, SW,   BUBL, 1};
        tbl[6]  = '{0, 0, 1, 5'd9, SW,   BUBL, 2};
        tbl[7]  = '{0, 0, 1, 5'd7, ADD,  BUBL, 3};
        tbl[8]  = '{0, 1, 1, 5'd5, ADD,  FLSH, 4};
        tbl[9]  = '{0, 0, 0, 5'd0, ADD,  NORM, 4};
        tbl[10] = '{1, 1, 1, 5'd5, ADD,  HOLD, 4};
        tbl[11] = '{0, 0, 0, 5'd0, ADD,  6'b110001, 4};
        tbl[12] = '{0, 0, 1, 5'd5, ADD,  BUBL, 4};
        tbl[13] = '{0, 0, 0, 5'd0, ADD,  NORM, 5};
        tbl[14] = '{0, 0, 1, 5'd5, JALR, BUBL, 5};
        tbl[15] = '{0, 0, 1, 5'd6, BEQ,  BUBL, 6};
        tbl[16] = '{0, 0, 1, 5'd0, ADD0, NORM, 7};

        do_reset();
        step(1, 0, 0, 0, 0, ADD);
        check("rst_outputs", 32'(oa), 32'(NORM));
        tick();
        for (int i = 0; i < 17; i++) begin
            step(0, tbl[i].busy, tbl[i].br, tbl[i].mr, tbl[i].rd, tbl[i].ins);
            check($sformatf("tbl%0d_out", i), 32'(oa), 32'(tbl[i].exp));
            check($sformatf("tbl%0d_cnt", i), 32'(ia.stall_count), tbl[i].cnt);
            tick();
        end

        // three-cycle load stall, then x0 exclusion
        do_reset();
        step(0, 0, 0, 1, 5, ADD);  check("ls3_c1", 32'(ob), 32'(BUBL)); tick();
        step(0, 0, 0, 0, 0, ADD);  check("ls3_c2", 32'(ob), 32'(BUBL)); tick();
        step(0, 0, 0, 0, 0, ADD);  check("ls3_c3", 32'(ob), 32'(BUBL)); tick();
        step(0, 0, 0, 0, 0, ADD);  check("ls3_end", 32'(ob), 32'(NORM));
        check("ls3_cnt", 32'(ib.stall_count), 3); tick();
        step(0, 0, 0, 1, 0, ADDI); check("ls3_x0", 32'(ob), 32'(NORM)); tick();

        // branch aborts a load stall and runs a two-cycle flush
        do_reset();
        step(0, 0, 0, 1, 5, ADD); check("br_c1", 32'(ob), 32'(BUBL)); tick();
        step(0, 0, 1, 0, 0, ADD); check("br_c2", 32'(ob), 32'(FLSH)); tick();
        step(0, 0, 0, 0, 0, ADD); check("br_c3", 32'(ob), 32'(FLSH)); tick();
        step(0, 0, 0, 0, 0, ADD); check("br_idle", 32'(ob), 32'(NORM));
        check("br_cnt", 32'(ib.stall_count), 1); tick();

        // memory wait in the middle of a load stall, branch ignored while frozen
        do_reset();
        step(0, 0, 0, 1, 5, ADD); check("mw_c1", 32'(ob), 32'(BUBL)); tick();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, (i == 1), 1, 5, ADD);
            check($sformatf("mw_hold%0d", i), 32'(ob), 32'(HOLD));
            check($sformatf("mw_cnt%0d", i), 32'(ib.stall_count), 1);
            tick();
        end
        step(0, 0, 0, 0, 0, ADD); check("mw_res1", 32'(ob), 32'(BUBL)); tick();
        step(0, 0, 0, 0, 0, ADD); check("mw_res2", 32'(ob), 32'(BUBL)); tick();
        step(0, 0, 0, 0, 0, ADD); check("mw_done", 32'(ob), 32'(NORM));
        check("mw_cnt", 32'(ib.stall_count), 3); tick();

        // saturation of the 4-bit counter, then reset in mid-stall
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, 5, ADD);
            tick();
        end
        step(0, 0, 0, 1, 5, ADD); check("sat_cnt", 32'(ib.stall_count), 15); tick();
        step(1, 0, 0, 1, 5, ADD); check("sat_rst", 32'(ob), 32'(NORM)); tick();
        step(0, 0, 0, 0, 0, ADD);
        check("post_rst_out", 32'(ob), 32'(NORM));
        check("post_rst_cnt", 32'(ib.stall_count), 0);
        tick();

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [4:0]  d;
            logic [31:0] ins;
            case ($urandom_range(0, 3))
                0: d = 5'd0;
                1: d = 5'd5;
                2: d = 5'd7;
                default: d = 5'($urandom);
            endcase
            ins = ($urandom_range(0, 7) == 7) ? $urandom : pool[$urandom_range(0, 6)];
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 1) == 1, d, ins);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
